// File: rtl/counter_display_pkg.sv
// Shared definitions for the counter_display slice: seven-segment patterns,
// converter FSM state encoding, digit/step counts and the hex-to-segment decoder.
package counter_display_pkg;

    localparam int DIGITS    = 8;
    localparam int BCD_STEPS = 24;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            4'hF:    pat = SEG_F;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/counter_display_if.sv
// Capture/display bundle between the stopwatch side (master) and counter_display (slave).
interface counter_display_if;
    logic [23:0] counter;
    logic        sample;
    logic        hold;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        busy;

    modport master (output counter, output sample, output hold,
                    input  seg,     input  an,     input  busy);
    modport slave  (input  counter, input  sample, input  hold,
                    output seg,     output an,     output busy);
endinterface

// File: rtl/counter_display_bin2bcd_dd.sv
// bin2bcd_dd: 24-bit binary to 8-digit BCD double-dabble converter.
// One shift step per cycle; busy is high for exactly BCD_STEPS cycles after start.
// done is high during the cycle whose closing edge performs the final shift,
// and bcd then carries the completed result so the caller can load it on that edge.
module bin2bcd_dd
    import counter_display_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] bin,
    output logic [31:0] bcd,
    output logic        done,
    output logic        busy
);

    localparam int STEP_W = 5;

    conv_state_t        state_r;
    logic [STEP_W-1:0]  step_r;
    logic [55:0]        shreg_r;   // {bcd[31:0], bin[23:0]}
    logic               busy_r;
    logic [55:0]        adj_s;
    logic [55:0]        shreg_next_s;

    // Add-3 correction on every BCD nibble >= 5, followed by the one-bit shift.
    always_comb begin
        adj_s = shreg_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (shreg_r[24 + 4*i +: 4] >= 4'd5) begin
                adj_s[24 + 4*i +: 4] = shreg_r[24 + 4*i +: 4] + 4'd3;
            end else begin
                adj_s[24 + 4*i +: 4] = shreg_r[24 + 4*i +: 4];
            end
        end
        shreg_next_s = {adj_s[54:0], 1'b0};
    end

    // Converter FSM: IDLE waits for start, CONV performs BCD_STEPS shift steps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            step_r  <= 5'd0;
            shreg_r <= 56'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shreg_r <= {32'd0, bin};
                        step_r  <= 5'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    shreg_r <= shreg_next_s;
                    if (step_r == STEP_W'(BCD_STEPS - 1)) begin
                        step_r  <= 5'd0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        step_r  <= step_r + 5'd1;
                    end
                end
                default: begin
                    step_r  <= 5'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = shreg_next_s[55:24];
    assign done = (state_r == ST_CONV) && (step_r == STEP_W'(BCD_STEPS - 1));
    assign busy = busy_r;

endmodule

// File: rtl/counter_display.sv
// counter_display: snapshots the 24-bit stopwatch counter and scans it onto an
// 8-digit common-anode seven-segment display, one digit per REFRESH_DIV cycles.
// Build option COUNTER_DISPLAY_BCD_EN: decimal display through the bin2bcd_dd
// converter; otherwise hex display with digits 6 and 7 blank.
module counter_display
    import counter_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic              clock,
    input  logic              reset,
    counter_display_if.slave  bus
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRESC_W-1:0] presc_r;
    logic [2:0]         idx_r;
    logic [31:0]        disp_r;
    logic [7:0]         seg_r;
    logic [7:0]         an_r;
    logic               busy_s;
    logic               capture_s;
    logic               blank_s;
    logic [3:0]         nibble_s;
    logic [7:0]         seg_s;
    logic [7:0]         an_s;

`ifdef COUNTER_DISPLAY_BCD_EN
    logic [31:0]        bcd_s;
    logic               done_s;

    bin2bcd_dd u_conv (
        .clock (clock),
        .reset (reset),
        .start (capture_s),
        .bin   (bus.counter),
        .bcd   (bcd_s),
        .done  (done_s),
        .busy  (busy_s)
    );
`else
    assign busy_s = 1'b0;
`endif

    // A sample is accepted only when not frozen and no conversion is running.
    assign capture_s = bus.sample & ~bus.hold & ~busy_s;

    // Display value: loaded on capture (hex) or on the final conversion shift (BCD).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_r <= 32'd0;
        end else begin
`ifdef COUNTER_DISPLAY_BCD_EN
            if (done_s) begin
                disp_r <= bcd_s;
            end else begin
                disp_r <= disp_r;
            end
`else
            if (capture_s) begin
                disp_r <= {8'h00, bus.counter};
            end else begin
                disp_r <= disp_r;
            end
`endif
        end
    end

    // Decode the digit currently selected by the scan index.
    always_comb begin
        nibble_s = disp_r[{idx_r, 2'b00} +: 4];
`ifdef COUNTER_DISPLAY_BCD_EN
        blank_s  = 1'b0;
`else
        if (idx_r >= 3'd6) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
`endif
        if (blank_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(nibble_s);
        end
        an_s = ~(8'd1 << idx_r);
    end

    // Scan timing: prescaler advances the digit index; seg/an register index and pattern together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
            idx_r   <= 3'd0;
            seg_r   <= SEG_BLANK;
            an_r    <= 8'hFF;
        end else begin
            if (presc_r == PRESC_W'(REFRESH_DIV - 1)) begin
                presc_r <= '0;
                idx_r   <= idx_r + 3'd1;
            end else begin
                presc_r <= presc_r + PRESC_W'(1);
            end
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

    assign bus.seg  = seg_r;
    assign bus.an   = an_r;
    assign bus.busy = busy_s;

endmodule
